// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scanner.
package disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BRIGHT_W   = 3;

  typedef enum logic {
    GUARD  = 1'b0,
    ACTIVE = 1'b1
  } scan_state_t;
endpackage

// File: rtl/disp_scan_ctrl_lz_mask.sv
// Leading-zero blank mask: bit k set means digit k is dark. Digit 0 is never blanked.
module lz_mask (
  input  logic [15:0] value,
  input  logic        lz_en,
  output logic [3:0]  blank
);
  always_comb begin
    blank    = '0;
    blank[3] = lz_en && (value[15:12] == 4'h0);
    blank[2] = lz_en && (value[15:8]  == 8'h00);
    blank[1] = lz_en && (value[15:4]  == 12'h000);
  end
endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scanner for four digits: guard/active slots, PWM brightness,
// frame-synchronous shadow capture and leading-zero blanking. All outputs registered.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SLOT_CYCLES  = 12500,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         value,
  input  logic [BRIGHT_W-1:0] brightness,
  input  logic                lz_en,
  input  logic                hold,
  output logic [1:0]          digit,
  output logic [3:0]          num,
  output logic                disp_en,
  output logic                frame_tick,
  output scan_state_t         dbg_state
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int U  = (SLOT_CYCLES - GUARD_CYCLES) / 8;
  localparam logic [CW-1:0] LAST       = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

  if (GUARD_CYCLES < 1 || SLOT_CYCLES <= GUARD_CYCLES ||
      ((SLOT_CYCLES - GUARD_CYCLES) % 8) != 0) begin : g_bad_params
    $error("disp_scan_ctrl: illegal SLOT_CYCLES/GUARD_CYCLES combination");
  end

  scan_state_t         state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [1:0]          dig_n;
  logic                started;
  logic [15:0]         sh_value, eff_value;
  logic [BRIGHT_W-1:0] sh_bright, eff_bright;
  logic                sh_lz, eff_lz;
  logic                load;
  logic [3:0]          blank;
  logic [3:0]          num_n;
  logic                disp_en_n, frame_tick_n;
  int                  act_idx, on_lim;

  lz_mask u_lz_mask (
    .value (eff_value),
    .lz_en (eff_lz),
    .blank (blank)
  );

  // Frame start is the first edge after reset release or the edge after frame_tick;
  // the freshly captured inputs drive that very cycle's outputs.
  always_comb begin
    load       = !started || frame_tick;
    eff_value  = sh_value;
    eff_bright = sh_bright;
    eff_lz     = sh_lz;
    if (load && !hold) begin
      eff_value  = value;
      eff_bright = brightness;
      eff_lz     = lz_en;
    end

    state_n = state;
    cnt_n   = cnt;
    dig_n   = digit;
    if (started) begin
      if (cnt == LAST) begin
        cnt_n   = '0;
        state_n = GUARD;
        dig_n   = digit + 2'd1;
      end else begin
        cnt_n = cnt + 1'b1;
        if (cnt == GUARD_LAST) state_n = ACTIVE;
      end
    end

    act_idx      = int'(cnt_n) - GUARD_CYCLES;
    on_lim       = U * (int'(eff_bright) + 1);
    disp_en_n    = (state_n == ACTIVE) && (act_idx < on_lim) && !blank[dig_n];
    num_n        = (cnt_n == '0) ? eff_value[{dig_n, 2'b00} +: 4] : num;
    frame_tick_n = (cnt_n == LAST) && (dig_n == 2'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= GUARD;
      cnt        <= '0;
      started    <= 1'b0;
      digit      <= '0;
      num        <= '0;
      disp_en    <= 1'b0;
      frame_tick <= 1'b0;
      sh_value   <= '0;
      sh_bright  <= '0;
      sh_lz      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      started    <= 1'b1;
      digit      <= dig_n;
      num        <= num_n;
      disp_en    <= disp_en_n;
      frame_tick <= frame_tick_n;
      sh_value   <= eff_value;
      sh_bright  <= eff_bright;
      sh_lz      <= eff_lz;
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SLOT_CYCLES=20, GUARD_CYCLES=4 (U=2, 80-cycle frame).
module tb_disp_scan_ctrl;
  import disp_pkg::*;

  localparam int SLOT  = 20;
  localparam int GRD   = 4;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [2:0]  brightness = '0;
  logic        lz_en = 1'b0;
  logic        hold = 1'b0;
  logic [1:0]  digit;
  logic [3:0]  num;
  logic        disp_en;
  logic        frame_tick;
  scan_state_t dbg_state;

  int tests = 0;
  int fails = 0;

  disp_scan_ctrl #(.SLOT_CYCLES(SLOT), .GUARD_CYCLES(GRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .brightness (brightness),
    .lz_en      (lz_en),
    .hold       (hold),
    .digit      (digit),
    .num        (num),
    .disp_en    (disp_en),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Invariants: no digit/num change while lit, never lit in GUARD.
  logic [1:0] prev_digit = '0;
  logic [3:0] prev_num = '0;
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (disp_en && (digit !== prev_digit || num !== prev_num)) begin
        fails++;
        $display("FAIL stable_while_lit: digit %0d num %h, previous digit %0d num %h", digit, num, prev_digit, prev_num);
      end
      tests++;
      if (dbg_state == GUARD && disp_en !== 1'b0) begin
        fails++;
        $display("FAIL guard_dark: disp_en %b in GUARD, required 0", disp_en);
      end
    end
    prev_digit = digit;
    prev_num   = num;
  end

  // Checks one whole frame starting at cycle 0; optional mid-frame value change.
  task automatic check_frame(input string name, input logic [15:0] exp_num, input logic [3:0] exp_lit,
                             input int on_cyc, input int mid_at, input logic [15:0] mid_value);
    logic [15:0] nib;
    logic [1:0]  d;
    logic [3:0]  en;
    int          s;
    logic        en_exp, ft_exp;
    nib = exp_num;
    en  = exp_lit;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      d      = 2'(c / SLOT);
      s      = c % SLOT;
      en_exp = (s >= GRD) && ((s - GRD) < on_cyc) && en[d];
      ft_exp = (c == FRAME - 1);
      tests++;
      if (digit !== d || num !== nib[{d, 2'b00} +: 4] || disp_en !== en_exp || frame_tick !== ft_exp) begin
        fails++;
        $display("FAIL %s cycle %0d: digit %0d num %h en %b tick %b, required digit %0d num %h en %b tick %b",
                 name, c, digit, num, disp_en, frame_tick, d, nib[{d, 2'b00} +: 4], en_exp, ft_exp);
      end
      if (c == mid_at) value = mid_value;
    end
  endtask

  task automatic apply_reset(input logic [15:0] v, input logic [2:0] b, input logic lz);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    value = v; brightness = b; lz_en = lz; hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (digit !== 2'd0 || num !== 4'h0 || disp_en !== 1'b0 || frame_tick !== 1'b0 || dbg_state !== GUARD) begin
      fails++;
      $display("FAIL reset_state: digit %0d num %h en %b tick %b state %0d, required all 0/GUARD",
               digit, num, disp_en, frame_tick, dbg_state);
    end
  endtask

  task automatic test_full_brightness();
    apply_reset(16'h1234, 3'd7, 1'b0);
    check_frame("full_bright_f0", 16'h1234, 4'b1111, 16, -1, 16'h0);
    check_frame("full_bright_f1", 16'h1234, 4'b1111, 16, -1, 16'h0);
  endtask

  task automatic test_no_tearing();
    check_frame("no_tear_old", 16'h1234, 4'b1111, 16, 30, 16'h5678);
    check_frame("no_tear_new", 16'h5678, 4'b1111, 16, -1, 16'h0);
  endtask

  task automatic test_min_brightness();
    brightness = 3'd0;
    check_frame("min_bright", 16'h5678, 4'b1111, 2, -1, 16'h0);
    brightness = 3'd3;
    check_frame("mid_bright", 16'h5678, 4'b1111, 8, -1, 16'h0);
  endtask

  task automatic test_lz_blank();
    value = 16'h0070; brightness = 3'd7; lz_en = 1'b1;
    check_frame("lz_0070", 16'h0070, 4'b0011, 16, -1, 16'h0);
    value = 16'h0000;
    check_frame("lz_0000", 16'h0000, 4'b0001, 16, -1, 16'h0);
    value = 16'h0305;
    check_frame("lz_0305", 16'h0305, 4'b0111, 16, -1, 16'h0);
    value = 16'h0070; lz_en = 1'b0;
    check_frame("lz_off", 16'h0070, 4'b1111, 16, -1, 16'h0);
  endtask

  task automatic test_hold();
    value = 16'h0305; lz_en = 1'b1;
    check_frame("hold_prime", 16'h0305, 4'b0111, 16, -1, 16'h0);
    hold = 1'b1; value = 16'h9ABC; brightness = 3'd3; lz_en = 1'b0;
    for (int f = 0; f < 3; f++) check_frame("hold_frozen", 16'h0305, 4'b0111, 16, -1, 16'h0);
    hold = 1'b0;
    check_frame("hold_release", 16'h9ABC, 4'b1111, 8, -1, 16'h0);
  endtask

  task automatic test_reset_mid_active();
    repeat (2 * SLOT + GRD + 6) @(negedge clk);
    tests++;
    if (digit !== 2'd2 || disp_en !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_lit: digit %0d en %b, required digit 2 en 1", digit, disp_en);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (disp_en !== 1'b0 || digit !== 2'd0 || frame_tick !== 1'b0 || dbg_state !== GUARD) begin
      fails++;
      $display("FAIL async_reset: en %b digit %0d tick %b state %0d, required 0/0/0/GUARD",
               disp_en, digit, frame_tick, dbg_state);
    end
    apply_reset(16'h4321, 3'd7, 1'b0);
    check_frame("after_reset", 16'h4321, 4'b1111, 16, -1, 16'h0);
  endtask

  initial begin
    test_reset();
    test_full_brightness();
    test_no_tearing();
    test_min_brightness();
    test_lz_blank();
    test_hold();
    test_reset_mid_active();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter SLOT_CYCLES, default 12500: clock cycles per digit slot (250 us at 50 MHz, 1 kHz frame rate).
REQ-002 Parameter GUARD_CYCLES, default 500: blanked cycles at the start of each slot, for anti-ghosting.
REQ-003 Parameter legality: GUARD_CYCLES >= 1; SLOT_CYCLES > GUARD_CYCLES; (SLOT_CYCLES-GUARD_CYCLES) divisible by 8. Violation SHALL be a $error at elaboration.
REQ-004 clk  input  1  system clock, CLOCK_50 domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 value  input  16  four BCD/hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-007 brightness  input  3  duty level; on-fraction = (brightness+1)/8 of the active phase.
REQ-008 lz_en  input  1  1 = blank leading zeros.
REQ-009 hold  input  1  1 = freeze shadow registers (display keeps the last captured frame).
REQ-010 digit  output  2  digit select, to the digit-cathode decoder.
REQ-011 num  output  4  nibble for the 7-segment decoder.
REQ-012 disp_en  output  1  1 = selected digit SHALL be lit; 0 = all digits dark.
REQ-013 frame_tick  output  1  one-cycle pulse on the last cycle of digit 3's slot.

Function
REQ-014 FSM states: GUARD, ACTIVE. A slot SHALL be GUARD for GUARD_CYCLES cycles, then ACTIVE for SLOT_CYCLES-GUARD_CYCLES cycles, then GUARD of the next slot.
REQ-015 Digit order SHALL be 0,1,2,3,0,... with 3 wrapping to 0 and no idle cycle between slots.
REQ-016 Shadow registers (value, brightness, lz_en) SHALL load on frame_start: the first cycle after reset deassertion, and the cycle following each frame_tick, unless hold=1.
REQ-017 Mid-frame input changes SHALL have no visible effect until the next frame_start (no tearing).
REQ-018 Let U = (SLOT_CYCLES-GUARD_CYCLES)/8 and let a = the ACTIVE cycle index, 0-based. disp_en SHALL be 1 iff state=ACTIVE, a < U*(shadow brightness+1), and the digit is not blanked.
REQ-019 disp_en SHALL be 0 in every GUARD cycle.
REQ-020 Leading-zero blanking with shadow lz_en=1: digit k (k=3..1) SHALL be blanked iff its nibble and every higher nibble are 0. Digit 0 SHALL never be blanked.
REQ-021 digit and num SHALL change only on the first GUARD cycle of a slot, never while disp_en=1.
REQ-022 All outputs SHALL be registered, with zero combinational paths from inputs to outputs.
REQ-023 Counter widths: slot counter = $clog2(SLOT_CYCLES) bits; the product U*8 SHALL be computed without overflow.

Reset
REQ-024 While reset=1: state=GUARD, digit=0, num=0, disp_en=0, frame_tick=0, slot counter=0, shadow registers=0.
REQ-025 Reset asserted mid-slot SHALL force disp_en=0 immediately (asynchronous). After release, the sequence SHALL restart with digit 0 GUARD.

Structure
REQ-026 Package disp_pkg SHALL hold NUM_DIGITS=4, the scan_state_t enum {GUARD, ACTIVE}, and the brightness width.
REQ-027 Sub-module lz_mask (combinational: 16-bit value, lz_en -> 4-bit blank mask) SHALL be instantiated once.
REQ-028 The block SHALL drive the existing decode2/decode7 datapath. The top level SHALL gate ct off when disp_en=0.

Verification (SLOT_CYCLES=20, GUARD_CYCLES=4, so U=2)
REQ-029 Release reset, value=16'h1234, brightness=7 -> digits 0,1,2,3 with num 4,3,2,1; disp_en = 4 low then 16 high per slot; frame_tick every 80 cycles.
REQ-030 brightness=0 -> disp_en high exactly 2 cycles per slot, on ACTIVE indices 0-1.
REQ-031 value=16'h0070, lz_en=1 -> digits 3 and 2 never lit; digit 1 shows 7; digit 0 shows 0 lit.
REQ-032 Change value mid-frame -> old value displayed until the cycle after frame_tick. With hold=1, there is no update across 3 frames.
REQ-033 Assert reset during ACTIVE of digit 2 -> disp_en=0 in the same cycle; after release, digit=0 with a 4-cycle GUARD.
REQ-034 Assertion across all runs: digit/num stable whenever disp_en=1, and disp_en=0 in all GUARD cycles.
